dmem_responder: RTL and testbench

- Memory-side responder for the CPU data port.
- Accepts load/store requests from an initiator over a valid/ready request channel and performs them on an internal 64-bit word array after a fixed number of wait cycles.
- Returns the result on a valid/ready response channel, with an error flag.
- Replaces the ideal zero-wait data memory when the core is moved to a handshaked memory interface.

---
 rtl/dmem_defs.sv | 24 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_defs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_defs : shared state encodings and address helpers for dmem_responder
// Revision  : 1.0
// ---------------------------------------------------------------------------
package dmem_defs;

  localparam int WORD_BYTES  = 8;
  localparam int OFFSET_BITS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Misaligned, or word index beyond the array.
  function automatic logic addr_err(input logic [63:0] addr, input int depth);
    return (addr[OFFSET_BITS-1:0] != '0) ||
           ({{OFFSET_BITS{1'b0}}, addr[63:OFFSET_BITS]} >= 64'(depth));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_array : DEPTH_WORDS x 64 storage, one sync write and one sync read port
// Revision   : 1.0
// ---------------------------------------------------------------------------
module dmem_array #(
  parameter  int DEPTH_WORDS = 128,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem_q [DEPTH_WORDS];
  logic [63:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (we) mem_q[idx] <= wdata;
    if (re) rdata_q    <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder : handshaked load/store responder with fixed access latency
// Revision       : 1.0
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_defs::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [63:0]        wdata_q, wdata_d;
  logic               commit;
  logic [63:0]        arr_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          err_d   = addr_err(req_addr, DEPTH_WORDS);
          idx_d   = req_addr[IDX_W+OFFSET_BITS-1:OFFSET_BITS];
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Reset forces IDLE, so a store still in WAIT can never reach the array.
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .CLK   (CLK),
    .we    (commit && write_q && !err_q),
    .re    (commit && !write_q && !err_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign req_ready  = (state_q == IDLE) && resetl;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !write_q && !err_q) ? arr_rdata : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_responder : directed scoreboard bench for dmem_responder
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_ready = 1'b1;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .CLK        (CLK),
    .resetl     (resetl),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  bit   prev_v = 1'b0;

  // Monitor: latency on response rise, data/err on handshake.
  always @(negedge CLK) begin
    if (resetl) begin
      if (resp_valid && !prev_v) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: resp_valid rose with no request pending");
        end else if (cyc != q[0].due) begin
          fails++;
          $display("FAIL latency: resp_valid at cycle %0d, required %0d", cyc, q[0].due);
        end
      end
      if (resp_valid && resp_ready && q.size() != 0) begin
        m_e = q.pop_front();
        tests++;
        if (resp_rdata !== m_e.rdata || resp_err !== m_e.err) begin
          fails++;
          $display("FAIL resp: rdata=%h err=%b, required rdata=%h err=%b",
                   resp_rdata, resp_err, m_e.rdata, m_e.err);
        end
      end
    end
    prev_v = resp_valid;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic issue(input bit w, input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] exp_rd, input bit exp_err, input bit track);
    int n = 0;
    @(negedge CLK);
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_ready_timeout: req_ready=%b, required 1", req_ready);
      return;
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    if (track) q.push_back('{exp_rd, exp_err, cyc + 1 + LAT});
    @(negedge CLK);
    // Scramble fields after accept; DUT must ignore them.
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = a ^ 64'h8;
    req_wdata = ~d;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  logic [63:0] hold_rd;
  logic        hold_err;

  initial begin
    // Reset with a request pending: nothing accepted, outputs at reset values.
    req_valid = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
    end
    req_valid = 1'b0;
    resetl    = 1'b1;
    @(negedge CLK);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);

    // Store then load.
    issue(1'b1, 64'h10, 64'h00000000DEADBEEF, 64'd0, 1'b0, 1'b1);
    wait_done();
    issue(1'b0, 64'h10, 64'd0, 64'h00000000DEADBEEF, 1'b0, 1'b1);
    wait_done();

    // Misaligned accesses.
    issue(1'b1, 64'h08, 64'hA5A5A5A5_5A5A5A5A, 64'd0, 1'b0, 1'b1);
    wait_done();
    issue(1'b0, 64'h13, 64'd0, 64'd0, 1'b1, 1'b1);
    wait_done();
    issue(1'b1, 64'h0B, 64'hFFFF, 64'd0, 1'b1, 1'b1);
    wait_done();
    issue(1'b0, 64'h08, 64'd0, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 1'b1);
    wait_done();

    // Range boundary: last word valid, next word out of range.
    issue(1'b1, 64'h3F8, 64'h0123456789ABCDEF, 64'd0, 1'b0, 1'b1);
    wait_done();
    issue(1'b0, 64'h3F8, 64'd0, 64'h0123456789ABCDEF, 1'b0, 1'b1);
    wait_done();
    issue(1'b0, 64'h400, 64'd0, 64'd0, 1'b1, 1'b1);
    wait_done();
    issue(1'b0, 64'h8000_0000_0000_0010, 64'd0, 64'd0, 1'b1, 1'b1);
    wait_done();

    // Backpressure.
    resp_ready = 1'b0;
    issue(1'b0, 64'h10, 64'd0, 64'h00000000DEADBEEF, 1'b0, 1'b1);
    for (int i = 0; i < 10 && !resp_valid; i++) @(negedge CLK);
    chk("bp_valid_up", 64'(resp_valid), 64'd1);
    hold_rd  = resp_rdata;
    hold_err = resp_err;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_valid_hold", 64'(resp_valid), 64'd1);
      chk("bp_rdata_hold", resp_rdata, hold_rd);
      chk("bp_err_hold", 64'(resp_err), 64'(hold_err));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge CLK);
    #1 resp_ready = 1'b1;
    @(negedge CLK);
    chk("hs_req_ready_same_cycle", 64'(req_ready), 64'd0);
    @(negedge CLK);
    chk("post_hs_valid", 64'(resp_valid), 64'd0);
    chk("post_hs_rdata", resp_rdata, 64'd0);
    chk("post_hs_req_ready", 64'(req_ready), 64'd1);
    wait_done();

    // Reset during WAIT drops an uncommitted store.
    issue(1'b1, 64'h20, 64'h5555, 64'd0, 1'b0, 1'b1);
    wait_done();
    issue(1'b1, 64'h20, 64'h1234, 64'd0, 1'b0, 1'b0);
    #1 resetl = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_resp_rdata", resp_rdata, 64'd0);
    chk("midrst_resp_err", 64'(resp_err), 64'd0);
    repeat (2) @(negedge CLK);
    resetl = 1'b1;
    issue(1'b0, 64'h20, 64'd0, 64'h5555, 1'b0, 1'b1);
    wait_done();

    repeat (4) @(negedge CLK);
    chk("final_idle_valid", 64'(resp_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
